mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the CPU data bus, alongside the LED output driver. It decodes CPU stores to a data address and pushes each stored byte into an internal FIFO. An 8N1 serializer drains the FIFO onto the serial line at one bit per baud tick. A status word is readable on the bus, so firmware can poll for space before writing.

Parameters:
DATA_ADDR, 32'd12, store address; wdata[7:0] is pushed into the FIFO
STATUS_ADDR, 32'd16, read address for the status word; a store here clears the overflow flag
FIFO_DEPTH, 8, FIFO entries; must be a power of two, 2..16

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
mem_write  in  2  CPU store-size strobe; 2'b00 = no store, any other value = store
addr  in  32  CPU data address (write_direction)
wdata  in  32  CPU store data
baud_tick  in  1  one-clk-cycle enable pulse at the bit rate
rdata  out  32  status read data
tx  out  1  serial output, idle high

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied, FSM to IDLE, tx=1, overflow=0.
  - Edge-detect register cleared to 0.
  - rdata follows the reset FIFO state: 32'h1 (empty=1).
  - A frame in progress is abandoned; tx returns high immediately.
- Store detection:
  - wr_hit = (mem_write!=0 && addr==DATA_ADDR); clr_hit = (mem_write!=0 && addr==STATUS_ADDR).
  - The CPU clock is slower than clk, so a strobe can stay high for many clk cycles.
  - Each strobe is registered; action happens only on the first clk cycle of a rising edge. Exactly one push per store, however long the strobe lasts.
- Push on the wr_hit rising edge:
  - FIFO not full: write wdata[7:0]; count +1.
  - FIFO full and no pop in the same cycle: drop the byte, set overflow=1 (sticky).
  - FIFO full and a pop in the same cycle: accept the byte; count unchanged.
- Overflow clear: clr_hit rising edge sets overflow=0. If a clear and a new overflow happen in the same cycle, set wins.
- rdata, combinational:
  - When addr==STATUS_ADDR: {23'b0, count[4:0], overflow, busy, full, empty}, where count is bits 8:4, overflow bit 3, busy bit 2, full bit 1, empty bit 0.
  - busy = (state!=IDLE).
  - Otherwise rdata = 0.
- FSM (advances only on clk cycles with baud_tick=1):
  - IDLE: tx=1. On tick with FIFO not empty: pop the head into an 8-bit shift register, tx<=0, go to START.
  - START: on tick, tx<=shreg[0], bit_cnt<=0, go to DATA.
  - DATA: on tick with bit_cnt<7: shift right, tx<=next bit, bit_cnt+1. On tick with bit_cnt==7: tx<=1, go to STOP.
  - STOP: on tick with FIFO not empty: pop, tx<=0, go to START (back-to-back frames, no idle bit). Otherwise go to IDLE.
- Frame timing:
  - 10 tick periods per frame: start bit, 8 data bits LSB first, stop bit.
  - tx is registered and changes only on the clk edge where baud_tick=1.
  - Latency: a push into an empty FIFO while IDLE makes tx fall on the next baud_tick.
- FIFO: circular buffer; read and write pointers wrap modulo FIFO_DEPTH. A push and a pop in the same cycle leave count unchanged.
- baud_tick held high continuously: the FSM advances one step per clk cycle. This is a legal mode for simulation.

Test Plan:
1. Reset, then baud_tick every 16 clk; store 8'hA5 to addr 12 with mem_write=2'b01 held 40 clk -> one push only. tx = 0,1,0,1,0,0,1,0,1,1, each bit lasting 16 clk, then idle high. Status reads busy during the frame, then 32'h1.
2. Burst-store bytes 0x01..0x03 while IDLE -> three frames back-to-back, no gap between stop and start bits. FIFO count reads 3→2→1→0 as frames start.
3. Ticks gated off; store 9 bytes with FIFO_DEPTH=8 -> status = {count=8, overflow=1, full=1} = 32'h8A. The 9th byte is never transmitted. A store to addr 16 -> overflow=0, status 32'h82.
4. FIFO full; the 9th store's rising edge coincides with an IDLE-pop tick -> byte accepted, count stays 8, overflow stays 0.
5. Assert reset mid data bit 4 of a frame -> tx=1 in the same cycle with no clock needed; after release status reads 32'h1 and no residual frame is sent.
6. Push 20 bytes paced by polling the full flag -> all 20 received in order by a UART monitor. Exercises pointer wrap-around twice.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// CPU stores to DATA_ADDR queue a byte in a small FIFO; a store to STATUS_ADDR
// clears the sticky overflow flag. Stores are edge-detected because the CPU
// strobe may stay high for many clk cycles. The serializer drains the FIFO one
// bit per baud_tick and chains frames back-to-back while data is waiting.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit on the line, shift register loaded
// S_DATA  | data bits on the line, LSB first, bit_cnt_q = bit index
// S_STOP  | stop bit on the line; next frame may start directly
module mmio_uart_tx #(
  parameter logic [31:0] DATA_ADDR   = 32'd12,
  parameter logic [31:0] STATUS_ADDR = 32'd16,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        baud_tick,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          wr_hit_q, clr_hit_q;
  logic [1:0]    state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          tx_q, tx_d;

  logic wr_hit, clr_hit, push_edge, clr_edge;
  logic push, pop, empty, full, busy;
  logic unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign wr_hit    = (mem_write != 2'b00) && (addr == DATA_ADDR);
  assign clr_hit   = (mem_write != 2'b00) && (addr == STATUS_ADDR);
  assign push_edge = wr_hit && !wr_hit_q;
  assign clr_edge  = clr_hit && !clr_hit_q;

  assign empty = (count_q == 5'd0);
  assign full  = (count_q == 5'(FIFO_DEPTH));
  assign busy  = (state_q != S_IDLE);

  // A full FIFO still takes the byte when the serializer pops in the same cycle.
  assign push = push_edge && (!full || pop);

  // FIFO occupancy and sticky overflow; a new overflow beats a same-cycle clear.
  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 5'd1;
    else if (pop && !push)
      count_d = count_q - 5'd1;
    ovf_d = ovf_q;
    if (push_edge && full && !pop)
      ovf_d = 1'b1;
    else if (clr_edge)
      ovf_d = 1'b0;
  end

  // Serializer next state; only moves on baud ticks.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    if (baud_tick) begin
      case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = fifo_q[rptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end
        end
        S_START: begin
          tx_d      = shreg_q[0];
          bit_cnt_d = 3'd0;
          state_d   = S_DATA;
        end
        S_DATA: begin
          if (bit_cnt_q != 3'd7) begin
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = fifo_q[rptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wptr_q] <= wdata[7:0];
  end

  // Control registers; reset drops any frame in flight and raises the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= 5'd0;
      ovf_q     <= 1'b0;
      wr_hit_q  <= 1'b0;
      clr_hit_q <= 1'b0;
      state_q   <= S_IDLE;
      shreg_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      tx_q      <= 1'b1;
    end else begin
      wr_hit_q  <= wr_hit;
      clr_hit_q <= clr_hit;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      if (push)
        wptr_q <= wptr_q + 1'b1;
      if (pop)
        rptr_q <= rptr_q + 1'b1;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

  // Status word is only driven while the status address is on the bus.
  always_comb begin
    rdata = 32'h0;
    if (addr == STATUS_ADDR)
      rdata = {23'b0, count_q, ovf_q, busy, full, empty};
  end

  assign tx = tx_q;

endmodule
